// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller.
// Two result sources (A: ALU, B: load unit) compete for a single write-back
// path. Accepted results go into a small FIFO that drains one entry per cycle
// into a registered register-file write port. A per-register busy scoreboard
// tracks destinations reserved at issue until their write-back happens.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    // Source A (ALU)
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [1:0]               a_addr,
    input  logic [DATA_W-1:0]        a_data,
    // Source B (load unit)
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [1:0]               b_addr,
    input  logic [DATA_W-1:0]        b_data,
    // Destination reservation from issue
    input  logic                     claim_valid,
    input  logic [1:0]               claim_addr,
    output logic [3:0]               busy,
    // Register-file write port
    output logic                     rf_we,
    output logic [1:0]               rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [1:0]        r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Round-robin pointer: 0 means A is preferred, 1 means B is preferred
    logic              r_prio_b;

    // Registered write port and busy scoreboard
    logic              r_rf_we;
    logic [1:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [3:0]        r_busy;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_not_full;
    logic              w_a_hs;
    logic              w_b_hs;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_push_addr;
    logic [DATA_W-1:0] w_push_data;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [3:0]        w_busy_nxt;

    // Arbitration: single requester wins outright, contention follows the pointer
    always_comb begin
        w_grant_a = a_valid & (~b_valid | ~r_prio_b);
        w_grant_b = b_valid & (~a_valid |  r_prio_b);
    end

    // Readiness depends only on grant and current occupancy, never on the pop;
    // reset forces both low immediately
    always_comb begin
        w_not_full = (r_count != CNT_W'(DEPTH));
        a_ready    = w_grant_a & w_not_full & ~reset;
        b_ready    = w_grant_b & w_not_full & ~reset;
        w_a_hs     = a_valid & a_ready;
        w_b_hs     = b_valid & b_ready;
        w_push     = w_a_hs | w_b_hs;
        w_pop      = (r_count != '0);
    end

    // Select the payload of whichever source completed its handshake
    always_comb begin
        w_push_addr = a_addr;
        w_push_data = a_data;
        if (w_b_hs) begin
            w_push_addr = b_addr;
            w_push_data = b_data;
        end
    end

    // Occupancy update: simultaneous push and pop cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO payload storage; only written on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_addr[r_wr_ptr] <= w_push_addr;
        end
    end

    // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    // Round-robin pointer moves past the winner only when both sources contended
    // and the grant actually completed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_b <= 1'b0;
        end else if (a_valid && b_valid && w_push) begin
            r_prio_b <= ~r_prio_b;
        end
    end

    // Drain the FIFO head into the write port; register 0 entries are consumed silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_pop) begin
            r_rf_we    <= (r_mem_addr[r_rd_ptr] != 2'd0);
            r_rf_waddr <= r_mem_addr[r_rd_ptr];
            r_rf_wdata <= r_mem_data[r_rd_ptr];
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    // Busy scoreboard next state: clear on completed write, set on claim (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < 4; r++) begin
            if (r_rf_we && (r_rf_waddr == 2'(r))) w_busy_nxt[r] = 1'b0;
            if (claim_valid && (claim_addr == 2'(r))) w_busy_nxt[r] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy       = r_busy;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid, claim_valid;
    logic              a_ready, b_ready;
    logic [1:0]        a_addr, b_addr, claim_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic [3:0]        busy;
    logic              rf_we;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CW-1:0]     fifo_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DATA_W+1:0] m_q[$];
    logic              m_we;
    logic [1:0]        m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_busy;
    logic              m_prio_b;
    int                max_count;

    regfile_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .busy(busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_we     = 1'b0;
        m_waddr  = 2'd0;
        m_wdata  = '0;
        m_busy   = 4'b0;
        m_prio_b = 1'b0;
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, "_rf_we"},    rf_we,      m_we);
        chk({pfx, "_rf_waddr"}, rf_waddr,   m_waddr);
        chk({pfx, "_rf_wdata"}, rf_wdata,   m_wdata);
        chk({pfx, "_busy"},     busy,       m_busy);
        chk({pfx, "_count"},    fifo_count, m_q.size());
    endtask

    // One clock cycle: drive inputs, check readies, advance model across the edge,
    // then check registered outputs.
    task automatic step(input logic av, input logic [1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [1:0] ba, input logic [DATA_W-1:0] bd,
                        input logic cv, input logic [1:0] ca);
        logic ea, eb, room;
        logic [3:0] nb;
        logic [DATA_W+1:0] e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        claim_valid = cv; claim_addr = ca;
        #1;
        room = (m_q.size() < DEPTH);
        if (av && bv) begin
            ea = room && !m_prio_b;
            eb = room &&  m_prio_b;
        end else begin
            ea = room && av;
            eb = room && bv;
        end
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        @(posedge clk);
        // busy: clear from the write visible this cycle, then claim overrides
        nb = m_busy;
        if (m_we) nb[m_waddr] = 1'b0;
        if (cv && ca != 2'd0) nb[ca] = 1'b1;
        m_busy = nb;
        // drain head, based on pre-edge occupancy
        if (m_q.size() > 0) begin
            e       = m_q.pop_front();
            m_waddr = e[DATA_W+1:DATA_W];
            m_wdata = e[DATA_W-1:0];
            m_we    = (m_waddr != 2'd0);
        end else begin
            m_we = 1'b0;
        end
        if (ea) m_q.push_back({aa, ad});
        else if (eb) m_q.push_back({ba, bd});
        if (av && bv && (ea || eb)) m_prio_b = !m_prio_b;
        if (m_q.size() > max_count) max_count = m_q.size();
        #1;
        chk_regs("cyc");
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int we_pulses;
        reset = 1'b1;
        a_valid = 0; b_valid = 0; claim_valid = 0;
        a_addr = 0; b_addr = 0; claim_addr = 0; a_data = 0; b_data = 0;
        model_reset();
        max_count = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_regs("rst");
        chk("rst_a_ready", a_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single A push: write appears one cycle after the following edge, for one cycle
        step(1, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("single_cnt", fifo_count, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_we",    rf_we, 1'b1);
        chk("single_waddr", rf_waddr, 2'd2);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_we_off", rf_we, 1'b0);

        // Both sources always valid: grants alternate A,B,A,B
        max_count = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd1, 32'hA000_0000 + i, 1, 2'd2, 32'hB000_0000 + i, 0, 0);
            if (i >= 1) chk("alt_src", rf_waddr, ((i - 1) % 2 == 0) ? 2'd1 : 2'd2);
        end
        idle(2);
        chk("alt_maxcnt_le1", max_count <= 1, 1'b1);

        // Claim r3, then write r3: busy holds until the edge after the write cycle
        step(0, 0, 0, 0, 0, 0, 1, 2'd3);
        chk("claim3_set", busy[3], 1'b1);
        step(1, 2'd3, 32'h3333_0001, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("claim3_wr_busy", busy[3], 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("claim3_cleared", busy[3], 1'b0);
        // Re-claim coinciding with the write cycle: set wins
        step(0, 0, 0, 0, 0, 0, 1, 2'd3);
        step(0, 0, 0, 1, 2'd3, 32'h3333_0002, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("setwin_we", rf_we, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1, 2'd3);
        chk("setwin_busy", busy[3], 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Register 0: accepted and drained, never written, never busy
        we_pulses = 0;
        step(1, 2'd0, 32'h12345678, 0, 0, 0, 1, 2'd0);
        chk("r0_accept", fifo_count, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            if (rf_we) we_pulses++;
        end
        chk("r0_no_we", we_pulses, 0);
        chk("r0_cnt", fifo_count, 0);
        chk("r0_busy0", busy[0], 1'b0);

        // Invalid inputs carry garbage but must do nothing
        step(0, 2'd1, 32'hFFFF_FFFF, 0, 2'd2, 32'hEEEE_EEEE, 0, 2'd1);
        chk("inv_cnt", fifo_count, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), 2'($urandom), $urandom,
                 $urandom_range(0, 1), 2'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), 2'($urandom));
        end
        idle(2);
        chk("rand_maxcnt_le1", max_count <= 1, 1'b1);

        // Reset mid-operation with an entry queued and registers busy
        step(0, 0, 0, 0, 0, 0, 1, 2'd1);
        step(0, 0, 0, 0, 0, 0, 1, 2'd2);
        step(1, 2'd3, 32'hCAFE_0003, 0, 0, 0, 1, 2'd3);
        chk("pre_rst_busy", busy, 4'b1110);
        chk("pre_rst_cnt", fifo_count, 1);
        a_valid = 1'b1; a_addr = 2'd1; a_data = 32'h5555_5555;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_regs("async_rst");
        chk("async_rst_a_ready", a_ready, 1'b0);
        chk("async_rst_b_ready", b_ready, 1'b0);
        @(negedge clk);
        a_valid = 1'b0;
        reset = 1'b0;
        we_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            if (rf_we) we_pulses++;
        end
        chk("post_rst_no_we", we_pulses, 0);

        // Reset released at negedge; the very next edge accepts a push
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(0, 0, 0, 1, 2'd1, 32'hBEEF_0001, 0, 0);
        chk("first_edge_push", fifo_count, 1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
